// File: rtl/alarm_ctrl.sv
// Arm/disarm security controller: exit delay, entry delay and latched siren.
// Optional feature ALARM_AUTORESET_EN: siren times out after SIREN_CYCLES and the system re-arms.
module alarm_ctrl #(
  parameter int EXIT_CYCLES  = 16,
  parameter int ENTRY_CYCLES = 8,
  parameter int SIREN_CYCLES = 32,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       arm,
  input  logic       disarm,
  input  logic       trig,
  output logic       siren,
  output logic       armed,
  output logic       pending,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    DISARMED = 3'd0,
    EXIT     = 3'd1,
    ARMED    = 3'd2,
    ENTRY    = 3'd3,
    ALARM    = 3'd4
  } state_e;

  // Delays of N cycles load N-1 because the zero count is itself one cycle.
  localparam logic [CNT_W-1:0] EXIT_LOAD  = CNT_W'(EXIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  if (EXIT_CYCLES < 1 || EXIT_CYCLES > 2**CNT_W ||
      ENTRY_CYCLES < 1 || ENTRY_CYCLES > 2**CNT_W ||
      SIREN_CYCLES < 1 || SIREN_CYCLES > 2**CNT_W) begin : g_bad_param
    $error("alarm_ctrl: delay parameter outside 1..2**CNT_W");
  end

`ifdef ALARM_AUTORESET_EN
  localparam logic [CNT_W-1:0] SIREN_LOAD = CNT_W'(SIREN_CYCLES - 1);
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             siren_q, armed_q, pending_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (disarm) begin
      state_d = DISARMED;
      cnt_d   = '0;
    end else begin
      case (state_q)
        DISARMED: begin
          if (arm) begin
            state_d = EXIT;
            cnt_d   = EXIT_LOAD;
          end
        end
        EXIT: begin
          if (cnt_q == '0) state_d = ARMED;
          else             cnt_d   = cnt_q - CNT_ONE;
        end
        ARMED: begin
          if (trig) begin
            state_d = ENTRY;
            cnt_d   = ENTRY_LOAD;
          end
        end
        ENTRY: begin
          if (cnt_q == '0) begin
            state_d = ALARM;
`ifdef ALARM_AUTORESET_EN
            cnt_d   = SIREN_LOAD;
`else
            cnt_d   = '0;
`endif
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ALARM: begin
`ifdef ALARM_AUTORESET_EN
          if (cnt_q == '0) state_d = ARMED;
          else             cnt_d   = cnt_q - CNT_ONE;
`else
          cnt_d = '0;
`endif
        end
        default: begin
          state_d = DISARMED;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= DISARMED;
      cnt_q     <= '0;
      siren_q   <= 1'b0;
      armed_q   <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      siren_q   <= (state_d == ALARM);
      armed_q   <= (state_d == ARMED) || (state_d == ENTRY) || (state_d == ALARM);
      pending_q <= (state_d == EXIT) || (state_d == ENTRY);
    end
  end

  assign siren   = siren_q;
  assign armed   = armed_q;
  assign pending = pending_q;
  assign state   = state_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl with EXIT=4, ENTRY=3, SIREN=5 cycles.
module tb_alarm_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       arm = 1'b0, disarm = 1'b0, trig = 1'b0;
  logic       siren, armed, pending;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  alarm_ctrl #(
    .EXIT_CYCLES(4), .ENTRY_CYCLES(3), .SIREN_CYCLES(5), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .disarm(disarm), .trig(trig),
    .siren(siren), .armed(armed), .pending(pending), .state(state)
  );

  always #5 clk = ~clk;

  // Expected {siren, armed, pending, state} for a given state code.
  function automatic logic [5:0] outs(input logic [2:0] s);
    logic sr, ar, pe;
    sr = (s == 3'd4);
    ar = (s == 3'd2) || (s == 3'd3) || (s == 3'd4);
    pe = (s == 3'd1) || (s == 3'd3);
    return {sr, ar, pe, s};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    $display("t=%0t arm=%0b disarm=%0b trig=%0b -> state=%0d siren=%0b armed=%0b pending=%0b",
             $time, arm, disarm, trig, state, siren, armed, pending);
  endtask

  task automatic test_reset();
    logic [5:0] obs;
    #1 rst_n = 1'b0;
    #1;
    obs = {siren, armed, pending, state};
    n_checks++;
    if (obs !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_initial: got %b want %b", obs, 6'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Drive into ENTRY, then pull reset between clock edges.
    arm = 1'b1; tick(); arm = 1'b0;
    repeat (4) tick();
    trig = 1'b1; tick(); trig = 1'b0;
    tick();
    obs = {siren, armed, pending, state};
    n_checks++;
    if (obs !== outs(3'd3)) begin
      n_fail++;
      $display("FAIL reset_setup_entry: got %b want %b", obs, outs(3'd3));
    end
    #3 rst_n = 1'b0;
    #1;
    obs = {siren, armed, pending, state};
    n_checks++;
    if (obs !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_async_mid_entry: got %b want %b", obs, 6'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      obs = {siren, armed, pending, state};
      n_checks++;
      if (obs !== 6'b0) begin
        n_fail++;
        $display("FAIL reset_idle_%0d: got %b want %b", i, obs, 6'b0);
      end
    end
  endtask

  task automatic test_arm_sequence();
    logic [5:0] obs;
    arm = 1'b1; tick(); arm = 1'b0;
    obs = {siren, armed, pending, state};
    n_checks++;
    if (obs !== outs(3'd1)) begin
      n_fail++;
      $display("FAIL arm_edge0: got %b want %b", obs, outs(3'd1));
    end
    trig = 1'b1;
    arm  = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      obs = {siren, armed, pending, state};
      n_checks++;
      if (obs !== outs(3'd1)) begin
        n_fail++;
        $display("FAIL arm_exit_edge%0d: got %b want %b", k, obs, outs(3'd1));
      end
    end
    trig = 1'b0;
    tick();
    obs = {siren, armed, pending, state};
    n_checks++;
    if (obs !== outs(3'd2)) begin
      n_fail++;
      $display("FAIL arm_edge4_armed: got %b want %b", obs, outs(3'd2));
    end
    // arm still high in ARMED must be ignored.
    repeat (5) tick();
    arm = 1'b0;
    obs = {siren, armed, pending, state};
    n_checks++;
    if (obs !== outs(3'd2)) begin
      n_fail++;
      $display("FAIL armed_hold: got %b want %b", obs, outs(3'd2));
    end
  endtask

  task automatic test_entry_alarm();
    logic [5:0] obs;
    logic [2:0] exp_s;
    trig = 1'b1; tick(); trig = 1'b0;
    for (int k = 10; k <= 13; k++) begin
      if (k > 10) tick();
      exp_s = (k == 13) ? 3'd4 : 3'd3;
      obs = {siren, armed, pending, state};
      n_checks++;
      if (obs !== outs(exp_s)) begin
        n_fail++;
        $display("FAIL entry_edge%0d: got %b want %b", k, obs, outs(exp_s));
      end
    end
`ifdef ALARM_AUTORESET_EN
    trig = 1'b1;
    for (int k = 14; k <= 19; k++) begin
      tick();
      exp_s = (k <= 17) ? 3'd4 : (k == 18) ? 3'd2 : 3'd3;
      obs = {siren, armed, pending, state};
      n_checks++;
      if (obs !== outs(exp_s)) begin
        n_fail++;
        $display("FAIL autoreset_edge%0d: got %b want %b", k, obs, outs(exp_s));
      end
    end
    trig = 1'b0;
`else
    arm  = 1'b1;
    trig = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      obs = {siren, armed, pending, state};
      n_checks++;
      if (obs !== outs(3'd4)) begin
        n_fail++;
        $display("FAIL alarm_hold_%0d: got %b want %b", i, obs, outs(3'd4));
      end
    end
    arm  = 1'b0;
    trig = 1'b0;
`endif
    disarm = 1'b1; tick(); disarm = 1'b0;
    obs = {siren, armed, pending, state};
    n_checks++;
    if (obs !== 6'b0) begin
      n_fail++;
      $display("FAIL alarm_disarm: got %b want %b", obs, 6'b0);
    end
  endtask

  task automatic test_disarm_priority();
    logic [5:0] obs;
    arm = 1'b1; disarm = 1'b1; tick(); arm = 1'b0; disarm = 1'b0;
    obs = {siren, armed, pending, state};
    n_checks++;
    if (obs !== 6'b0) begin
      n_fail++;
      $display("FAIL disarm_vs_arm: got %b want %b", obs, 6'b0);
    end
    arm = 1'b1; tick(); arm = 1'b0;
    tick();
    disarm = 1'b1; tick(); disarm = 1'b0;
    obs = {siren, armed, pending, state};
    n_checks++;
    if (obs !== 6'b0) begin
      n_fail++;
      $display("FAIL disarm_in_exit: got %b want %b", obs, 6'b0);
    end
    // Back-to-back re-arm right after disarm must restart a full exit delay.
    arm = 1'b1; tick(); arm = 1'b0;
    repeat (3) tick();
    obs = {siren, armed, pending, state};
    n_checks++;
    if (obs !== outs(3'd1)) begin
      n_fail++;
      $display("FAIL rearm_exit_full: got %b want %b", obs, outs(3'd1));
    end
    tick();
    obs = {siren, armed, pending, state};
    n_checks++;
    if (obs !== outs(3'd2)) begin
      n_fail++;
      $display("FAIL rearm_armed: got %b want %b", obs, outs(3'd2));
    end
    trig = 1'b1; tick(); trig = 1'b0;
    tick();
    disarm = 1'b1; trig = 1'b1; tick(); disarm = 1'b0; trig = 1'b0;
    obs = {siren, armed, pending, state};
    n_checks++;
    if (obs !== 6'b0) begin
      n_fail++;
      $display("FAIL disarm_in_entry: got %b want %b", obs, 6'b0);
    end
    trig = 1'b1; tick(); trig = 1'b0;
    obs = {siren, armed, pending, state};
    n_checks++;
    if (obs !== 6'b0) begin
      n_fail++;
      $display("FAIL trig_in_disarmed: got %b want %b", obs, 6'b0);
    end
  endtask

  initial begin
    test_reset();
    test_arm_sequence();
    test_entry_alarm();
    test_disarm_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
